mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/brisc_pkg.sv | 17 +
 rtl/mem_ctrl_latency_counter.sv | 25 ++
 rtl/mem_ctrl.sv | 114 +++++++++++
 tb/tb_mem_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared widths, memory timing defaults and controller state encoding
package brisc_pkg;

    localparam int ADDRESS_WIDTH    = 32;
    localparam int CACHE_LINE_WIDTH = 128;
    localparam int MEM_LATENCY      = 5;
    localparam int MEM_LINES        = 4096;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        DRAIN
    } mem_ctrl_state_e;

endpackage

// File: rtl/mem_ctrl_latency_counter.sv
// latency_counter: loadable down-counter with a zero flag for the memory wait phase
module latency_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // load wins over decrement; otherwise hold
    always_comb cnt_d = load_i ? val_i : dec_i ? cnt_q - W'(1) : cnt_q;

    // count register, cleared asynchronously
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: fixed-latency single-request cache-line memory controller
module mem_ctrl #(
    parameter int MEM_LATENCY = brisc_pkg::MEM_LATENCY,
    parameter int MEM_LINES   = brisc_pkg::MEM_LINES
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   mem_req,
    input  logic                                   mem_write,
    input  logic [brisc_pkg::ADDRESS_WIDTH-1:0]    mem_addr,
    input  logic [brisc_pkg::CACHE_LINE_WIDTH-1:0] mem_data,
    output logic                                   mem_ready,
    output logic [brisc_pkg::CACHE_LINE_WIDTH-1:0] mem_rdata,
    output logic                                   mem_busy,
    output logic                                   ram_en,
    output logic                                   ram_we,
    output logic [$clog2(MEM_LINES)-1:0]           ram_addr,
    output logic [brisc_pkg::CACHE_LINE_WIDTH-1:0] ram_wdata,
    input  logic [brisc_pkg::CACHE_LINE_WIDTH-1:0] ram_rdata
);

    import brisc_pkg::*;

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int OFF   = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int CW    = $clog2(MEM_LATENCY + 1);

    mem_ctrl_state_e             state_q, state_d;
    logic                        we_q, we_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CACHE_LINE_WIDTH-1:0] data_q, data_d;
    logic                        load, dec, zero, latch;
    logic                        unused_addr;

    assign unused_addr = ^mem_addr;

    latency_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .dec_i  (dec),
        .val_i  (CW'(MEM_LATENCY - 1)),
        .zero_o (zero)
    );

    // request capture: high address bits above the index are dropped so addresses wrap
    always_comb begin
        we_d   = latch ? mem_write : we_q;
        idx_d  = latch ? mem_addr[OFF+IDX_W-1:OFF] : idx_q;
        data_d = latch ? mem_data : data_q;
    end

    // state and latched request, all cleared asynchronously
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end

    // next state and Moore outputs; an abort is only possible before ACCESS
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        dec       = 1'b0;
        latch     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_busy  = 1'b1;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                mem_busy = 1'b0;
                if (mem_req) begin
                    state_d = WAIT;
                    load    = 1'b1;
                    latch   = 1'b1;
                end
            end
            WAIT: begin
                if (!mem_req) state_d = IDLE;
                else if (zero) state_d = ACCESS;
                else dec = 1'b1;
            end
            ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_addr  = idx_q;
                ram_wdata = data_q;
                state_d   = RESP;
            end
            RESP: begin
                mem_ready = 1'b1;
                mem_rdata = we_q ? '0 : ram_rdata;
                state_d   = mem_req ? DRAIN : IDLE;
            end
            DRAIN: state_d = mem_req ? DRAIN : IDLE;
            default: begin
                mem_busy = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a behavioural synchronous RAM
module tb_mem_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mem_req = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [127:0] mem_data = '0;
    logic         mem_ready, mem_busy, ram_en, ram_we;
    logic [127:0] mem_rdata, ram_wdata;
    logic [127:0] ram_rdata = '0;
    logic [11:0]  ram_addr;
    logic [127:0] ram [0:4095];
    int           n_cmp = 0;
    int           n_err = 0;
    int           en_cnt = 0;
    int           en_base;

    localparam logic [127:0] LINE_A = 128'hDEADBEEF_0000_0001_CAFEF00D_12345678;
    localparam logic [127:0] LINE_W = {16{8'hA5}};
    localparam logic [127:0] LINE_T = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end

    always @(negedge clk)
        if (ram_en) en_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input string t, input logic w, input logic [31:0] a,
                           input logic [127:0] d, input logic [11:0] idx, input logic [127:0] rd);
        mem_req   = 1'b1;
        mem_write = w;
        mem_addr  = a;
        mem_data  = d;
        tick();
        check({t, "_busy1"}, mem_busy, 1);
        repeat (4) tick();
        check({t, "_en5"}, ram_en, 0);
        tick();
        check({t, "_en6"}, ram_en, 1);
        check({t, "_we6"}, ram_we, w);
        check({t, "_addr6"}, ram_addr, idx);
        check({t, "_wdata6"}, ram_wdata, w ? d : 128'h0);
        check({t, "_rdy6"}, mem_ready, 0);
        tick();
        check({t, "_rdy7"}, mem_ready, 1);
        check({t, "_rdata7"}, mem_rdata, rd);
        check({t, "_en7"}, ram_en, 0);
        mem_req = 1'b0;
        tick();
        check({t, "_idle"}, mem_busy, 0);
        check({t, "_rdy8"}, mem_ready, 0);
        check({t, "_rdata8"}, mem_rdata, 0);
    endtask

    initial begin
        ram[12'h010] = LINE_A;
        ram[12'hFFF] = LINE_T;
        #3;
        check("rst_busy", mem_busy, 0);
        check("rst_outs", {mem_ready, ram_en, ram_we, ram_addr, ram_wdata != 0, mem_rdata != 0}, 0);
        @(negedge clk) reset = 1'b1;
        tick();
        check("idle_busy", mem_busy, 0);

        run_req("read", 1'b0, 32'h0000_0100, '0, 12'h010, LINE_A);
        run_req("write", 1'b1, 32'h0000_0204, LINE_W, 12'h020, 128'h0);
        run_req("readback", 1'b0, 32'h0000_0200, '0, 12'h020, LINE_W);

        en_base   = en_cnt;
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0100;
        repeat (3) tick();
        mem_req = 1'b0;
        tick();
        check("abort_idle", mem_busy, 0);
        check("abort_rdy", mem_ready, 0);
        check("abort_en", en_cnt - en_base, 0);
        run_req("after_abort", 1'b0, 32'h0000_0100, '0, 12'h010, LINE_A);

        en_base  = en_cnt;
        mem_req  = 1'b1;
        mem_addr = 32'h0000_0200;
        repeat (7) tick();
        check("held_rdy", mem_ready, 1);
        check("held_rdata", mem_rdata, LINE_W);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_drain_busy", mem_busy, 1);
            check("held_drain_rdy", mem_ready, 0);
        end
        check("held_one_en", en_cnt - en_base, 1);
        mem_req = 1'b0;
        tick();
        check("held_idle", mem_busy, 0);
        run_req("after_held", 1'b0, 32'h0000_0100, '0, 12'h010, LINE_A);

        en_base  = en_cnt;
        mem_req  = 1'b1;
        mem_addr = 32'h0000_0100;
        repeat (3) tick();
        check("pre_rst_busy", mem_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async_busy", mem_busy, 0);
        check("async_outs", {mem_ready, ram_en, ram_we, ram_addr, ram_wdata != 0, mem_rdata != 0}, 0);
        mem_req = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (10) tick();
        check("rst_no_en", en_cnt - en_base, 0);
        check("rst_idle", mem_busy, 0);

        run_req("wrap", 1'b0, 32'hFFFF_FFF0, '0, 12'hFFF, LINE_T);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
